// File: rtl/de_sram_responder_pkg.sv
// Shared definitions for the drawing-engine SRAM responder: state encoding,
// byte-enable constants and beat-counter sizing.
package de_sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LO_BEAT = 2'd1,
    HI_BEAT = 2'd2,
    ACK     = 2'd3
  } de_state_e;

  localparam logic [3:0] NBYTE_NONE = 4'b1111;

  // Counter must hold 0 .. WAIT_CYCLES+1 (setup plus all strobe cycles).
  function automatic int unsigned beat_cnt_w(input int unsigned wait_cycles);
    return $clog2(wait_cycles + 2);
  endfunction

endpackage

// File: rtl/de_sram_responder_hword_beat.sv
// Setup/strobe timer for one SRAM halfword beat; back-to-back beats chain
// without a gap when start is raised in the final strobe cycle.
module sram_hword_beat
  import de_sram_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic rnw,
  output logic we_n,
  output logic oe_n,
  output logic capture,
  output logic done
);

  localparam int unsigned    CNT_W = beat_cnt_w(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WAIT_CYCLES + 1);

  logic             busy;
  logic             rnw_q;
  logic [CNT_W-1:0] cnt;

  assign done    = busy && (cnt == LAST);
  assign capture = done && rnw_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      rnw_q <= 1'b0;
      cnt   <= '0;
      we_n  <= 1'b1;
      oe_n  <= 1'b1;
    end else if (start && (!busy || done)) begin
      // Setup cycle: reads open the output enable immediately.
      busy  <= 1'b1;
      rnw_q <= rnw;
      cnt   <= '0;
      we_n  <= 1'b1;
      oe_n  <= !rnw;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
        we_n <= 1'b1;
        oe_n <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == '0) we_n <= rnw_q;
      end
    end
  end

endmodule

// File: rtl/de_sram_responder.sv
// Drawing-engine memory responder: one 32-bit word per request, split into
// low/high 16-bit beats on an asynchronous SRAM with configurable wait states.
module de_sram_responder
  import de_sram_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              de_req,
  output logic              de_ack,
  input  logic [ADDR_W-1:0] de_addr,
  input  logic [3:0]        de_nbyte,
  input  logic              de_rnw,
  input  logic [31:0]       de_w_data,
  output logic [31:0]       de_r_data,
  output logic [ADDR_W:0]   sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  output logic              sram_data_oe,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  de_state_e         state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        nbyte_hi_q;
  logic [15:0]       wdata_hi_q;
  logic              rnw_q;

  logic beat_start;
  logic beat_rnw;
  logic beat_done;
  logic beat_capture;

  // Beat start is decided in the cycle before the beat so the timer and the
  // address/lane registers all load on the same edge.
  always_comb begin
    beat_start = 1'b0;
    beat_rnw   = rnw_q;
    if (state == IDLE) begin
      beat_rnw   = de_rnw;
      beat_start = de_req && (de_rnw || (de_nbyte != NBYTE_NONE));
    end else if (state == LO_BEAT) begin
      beat_start = beat_done && (rnw_q || (nbyte_hi_q != 2'b11));
    end
  end

  sram_hword_beat #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_beat (
    .clk    (clk),
    .reset  (reset),
    .start  (beat_start),
    .rnw    (beat_rnw),
    .we_n   (sram_we_n),
    .oe_n   (sram_oe_n),
    .capture(beat_capture),
    .done   (beat_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      de_ack       <= 1'b0;
      de_r_data    <= '0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      sram_data_oe <= 1'b0;
      sram_lb_n    <= 1'b1;
      sram_ub_n    <= 1'b1;
      addr_q       <= '0;
      nbyte_hi_q   <= 2'b11;
      wdata_hi_q   <= '0;
      rnw_q        <= 1'b0;
    end else begin
      de_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (de_req) begin
            addr_q     <= de_addr;
            nbyte_hi_q <= de_nbyte[3:2];
            wdata_hi_q <= de_w_data[31:16];
            rnw_q      <= de_rnw;
            if (de_rnw || (de_nbyte[1:0] != 2'b11)) begin
              state        <= LO_BEAT;
              sram_addr    <= {de_addr, 1'b0};
              sram_wdata   <= de_w_data[15:0];
              sram_lb_n    <= de_rnw ? 1'b0 : de_nbyte[0];
              sram_ub_n    <= de_rnw ? 1'b0 : de_nbyte[1];
              sram_data_oe <= !de_rnw;
            end else if (de_nbyte[3:2] != 2'b11) begin
              state        <= HI_BEAT;
              sram_addr    <= {de_addr, 1'b1};
              sram_wdata   <= de_w_data[31:16];
              sram_lb_n    <= de_nbyte[2];
              sram_ub_n    <= de_nbyte[3];
              sram_data_oe <= 1'b1;
            end else begin
              state  <= ACK;
              de_ack <= 1'b1;
            end
          end
        end
        LO_BEAT: begin
          if (beat_done) begin
            if (beat_capture) de_r_data[15:0] <= sram_rdata;
            if (rnw_q || (nbyte_hi_q != 2'b11)) begin
              state        <= HI_BEAT;
              sram_addr    <= {addr_q, 1'b1};
              sram_wdata   <= wdata_hi_q;
              sram_lb_n    <= rnw_q ? 1'b0 : nbyte_hi_q[0];
              sram_ub_n    <= rnw_q ? 1'b0 : nbyte_hi_q[1];
              sram_data_oe <= !rnw_q;
            end else begin
              state        <= ACK;
              de_ack       <= 1'b1;
              sram_data_oe <= 1'b0;
              sram_lb_n    <= 1'b1;
              sram_ub_n    <= 1'b1;
            end
          end
        end
        HI_BEAT: begin
          if (beat_done) begin
            if (beat_capture) de_r_data[31:16] <= sram_rdata;
            state        <= ACK;
            de_ack       <= 1'b1;
            sram_data_oe <= 1'b0;
            sram_lb_n    <= 1'b1;
            sram_ub_n    <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_de_sram_responder.sv
// Self-checking bench: behavioural SRAM plus a word-level reference memory,
// directed scenarios followed by randomized accesses.
module tb_de_sram_responder;

  localparam int unsigned WAIT_CYCLES = 1;
  localparam int unsigned ADDR_W      = 18;
  localparam int          B           = WAIT_CYCLES + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              de_req = 1'b0;
  logic              de_ack;
  logic [ADDR_W-1:0] de_addr = '0;
  logic [3:0]        de_nbyte = 4'b1111;
  logic              de_rnw = 1'b0;
  logic [31:0]       de_w_data = '0;
  logic [31:0]       de_r_data;
  logic [ADDR_W:0]   sram_addr;
  logic [15:0]       sram_wdata;
  logic [15:0]       sram_rdata = 16'hDEAD;
  logic              sram_data_oe;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_lb_n;
  logic              sram_ub_n;

  de_sram_responder #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .de_req      (de_req),
    .de_ack      (de_ack),
    .de_addr     (de_addr),
    .de_nbyte    (de_nbyte),
    .de_rnw      (de_rnw),
    .de_w_data   (de_w_data),
    .de_r_data   (de_r_data),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .sram_data_oe(sram_data_oe),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_lb_n   (sram_lb_n),
    .sram_ub_n   (sram_ub_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram_mem [int];
  logic [31:0] ref_mem  [int];

  function automatic logic [15:0] init_hw(input int a);
    logic [31:0] t;
    t = (a * 32'h9E37) ^ 32'h5A5A;
    return t[15:0];
  endfunction

  function automatic logic [15:0] hw_rd(input int a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return init_hw(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return {init_hw(2 * a + 1), init_hw(2 * a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus monitor / SRAM model, evaluated mid-cycle.
  int                mon_we = 0;
  int                mon_oe = 0;
  bit                mon_lo = 0;
  bit                mon_hi = 0;
  bit                mon_addr_bad = 0;
  bit                mon_dir_bad = 0;
  logic [ADDR_W-1:0] cur_addr = '0;
  logic [ADDR_W:0]   last_addr = '0;
  logic              last_lb = 1'b1;
  logic              last_ub = 1'b1;
  logic [15:0]       last_wd = '0;

  always @(negedge clk) begin
    if (!reset) begin
      sram_rdata = sram_oe_n ? 16'hDEAD : hw_rd(int'(sram_addr));
      if (!sram_we_n || !sram_oe_n) begin
        logic [15:0] h;
        if (!sram_we_n) mon_we++;
        if (!sram_oe_n) mon_oe++;
        if (sram_addr[0]) mon_hi = 1; else mon_lo = 1;
        if (sram_addr[ADDR_W:1] != cur_addr) mon_addr_bad = 1;
        if ((!sram_we_n && (!sram_data_oe || !sram_oe_n)) || (!sram_oe_n && sram_data_oe))
          mon_dir_bad = 1;
        last_addr = sram_addr;
        last_lb   = sram_lb_n;
        last_ub   = sram_ub_n;
        last_wd   = sram_wdata;
        if (!sram_we_n) begin
          h = hw_rd(int'(sram_addr));
          if (!sram_lb_n) h[7:0]  = sram_wdata[7:0];
          if (!sram_ub_n) h[15:8] = sram_wdata[15:8];
          sram_mem[int'(sram_addr)] = h;
        end
      end
    end
  end

  task automatic mon_clear();
    mon_we = 0; mon_oe = 0; mon_lo = 0; mon_hi = 0;
    mon_addr_bad = 0; mon_dir_bad = 0;
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
    chk({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
    chk({tag, "_lb_n"}, 32'(sram_lb_n), 32'd1);
    chk({tag, "_ub_n"}, 32'(sram_ub_n), 32'd1);
    chk({tag, "_data_oe"}, 32'(sram_data_oe), 32'd0);
    chk({tag, "_ack"}, 32'(de_ack), 32'd0);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
    chk({tag, "_rdata"}, de_r_data, 32'd0);
  endtask

  task automatic access(input logic [ADDR_W-1:0] a, input logic [3:0] nb, input logic rnw,
                        input logic [31:0] wd, input bit drop);
    int          lat;
    int          beats;
    bit          got;
    bit          exp_lo;
    bit          exp_hi;
    logic [31:0] exp_word;
    logic [31:0] prev_rd;
    exp_lo   = rnw || (nb[1:0] != 2'b11);
    exp_hi   = rnw || (nb[3:2] != 2'b11);
    beats    = int'(exp_lo) + int'(exp_hi);
    exp_word = ref_rd(int'(a));
    if (!rnw)
      for (int i = 0; i < 4; i++)
        if (!nb[i]) exp_word[8*i +: 8] = wd[8*i +: 8];
    @(negedge clk);
    prev_rd   = de_r_data;
    de_addr   = a;
    de_nbyte  = nb;
    de_rnw    = rnw;
    de_w_data = wd;
    de_req    = 1'b1;
    cur_addr  = a;
    mon_clear();
    @(posedge clk);
    lat = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (drop) de_req = 1'b0;
      if (de_ack) got = 1; else lat++;
    end
    de_req = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(lat), 32'(beats * B));
    chk("we_cycles", 32'(mon_we), rnw ? 32'd0 : 32'(beats * (WAIT_CYCLES + 1)));
    chk("oe_cycles", 32'(mon_oe), rnw ? 32'(2 * B) : 32'd0);
    chk("lo_beat", 32'(mon_lo), 32'(exp_lo));
    chk("hi_beat", 32'(mon_hi), 32'(exp_hi));
    chk("beat_addr", 32'(mon_addr_bad), 32'd0);
    chk("bus_dir", 32'(mon_dir_bad), 32'd0);
    if (rnw) begin
      chk("read_data", de_r_data, exp_word);
    end else begin
      ref_mem[int'(a)] = exp_word;
      chk("mem_word", {hw_rd(2 * int'(a) + 1), hw_rd(2 * int'(a))}, exp_word);
      chk("rdata_hold", de_r_data, prev_rd);
    end
    @(negedge clk);
    chk("ack_single", 32'(de_ack), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  lanes [4];
    logic [31:0] wd;
    int          cnt;
    int          acks;
    bit          got;

    // Power-on reset.
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset_values("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single LO beat.
    access(18'h00010, 4'b1110, 1'b0, 32'h0000_0005, 1'b0);
    chk("t2_addr", 32'(last_addr), 32'h20);
    chk("t2_lb", 32'(last_lb), 32'd0);
    chk("t2_ub", 32'(last_ub), 32'd1);
    chk("t2_wdata", 32'(last_wd), 32'h0005);

    // Single HI beat.
    access(18'h00011, 4'b0111, 1'b0, 32'h0700_0000, 1'b0);
    chk("t3_addr", 32'(last_addr), 32'h23);
    chk("t3_lb", 32'(last_lb), 32'd1);
    chk("t3_ub", 32'(last_ub), 32'd0);
    chk("t3_wdata", 32'(last_wd), 32'h0700);

    // Read at the top address.
    sram_mem[19'h7FFFE] = 16'h1234;
    sram_mem[19'h7FFFF] = 16'hABCD;
    ref_mem[18'h3FFFF]  = 32'hABCD_1234;
    access(18'h3FFFF, 4'b0000, 1'b1, 32'h0, 1'b0);
    chk("t4_rdata", de_r_data, 32'hABCD_1234);
    chk("t4_last_addr", 32'(last_addr), 32'h7FFFF);

    // No enabled lanes: immediate ack.
    access(18'h00012, 4'b1111, 1'b0, 32'hFFFF_FFFF, 1'b0);

    // Reset while idle.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 reset_values("rst_idle");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset during a write strobe.
    de_addr = 18'h00100; de_nbyte = 4'b0000; de_rnw = 1'b0;
    de_w_data = 32'hCAFE_F00D; de_req = 1'b1; cur_addr = 18'h00100;
    for (int i = 0; i < 20 && sram_we_n; i++) @(negedge clk);
    chk("rst_we_low_reached", 32'(sram_we_n), 32'd0);
    #2 reset = 1'b1;
    #1 reset_values("rst_write");
    de_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 3 * B; i++) begin
      @(negedge clk);
      if (de_ack) acks++;
    end
    chk("rst_no_ack", 32'(acks), 32'd0);

    // Request held high across four single-lane writes.
    lanes[0] = 4'b1110; lanes[1] = 4'b1101; lanes[2] = 4'b1011; lanes[3] = 4'b0111;
    mon_clear();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      wd = $urandom;
      de_addr = ADDR_W'(32 + k); de_nbyte = lanes[k]; de_rnw = 1'b0;
      de_w_data = wd; de_req = 1'b1; cur_addr = ADDR_W'(32 + k);
      w = ref_rd(32 + k);
      for (int i = 0; i < 4; i++)
        if (!lanes[k][i]) w[8*i +: 8] = wd[8*i +: 8];
      ref_mem[32 + k] = w;
      cnt = 0;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        cnt++;
        if (de_ack) got = 1;
      end
      chk("held_ack_seen", 32'(got), 32'd1);
      chk("held_ack_spacing", 32'(cnt), (k == 0) ? 32'(B + 1) : 32'(B + 2));
    end
    de_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 2 * B; i++) begin
      @(negedge clk);
      if (de_ack) acks++;
    end
    chk("held_no_extra_ack", 32'(acks), 32'd0);
    chk("held_we_cycles", 32'(mon_we), 32'(4 * (WAIT_CYCLES + 1)));
    chk("held_dir", 32'(mon_dir_bad), 32'd0);
    for (int k = 0; k < 4; k++)
      chk("held_mem", {hw_rd(2 * (32 + k) + 1), hw_rd(2 * (32 + k))}, ref_rd(32 + k));

    // Randomized mix over a small address pool, including the top address.
    for (int n = 0; n < 40; n++) begin
      logic [ADDR_W-1:0] a;
      a = ($urandom_range(0, 8) == 8) ? '1 : ADDR_W'($urandom_range(0, 7));
      access(a, 4'($urandom), 1'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 8; n++) access(ADDR_W'(n), 4'b0000, 1'b1, 32'h0, 1'b0);
    access('1, 4'b0000, 1'b1, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/de_sram_responder.md
Name: de_sram_responder

Overview:
- Responder end of the drawing-engine memory interface (`de_req`/`de_ack`/`de_addr`/`de_nbyte`/`de_rnw`/`de_w_data`/`de_r_data`).
- Services one 32-bit word access per request from a dithering/drawing initiator.
- Backing store is an external 16-bit asynchronous SRAM. Each word is split into a low and a high halfword beat, with configurable wait states.
- Sits between the drawing engines and the framebuffer SRAM pins; tri-state of the data bus is resolved at top level.

Parameters:
- WAIT_CYCLES, 1, extra strobe cycles per SRAM beat (>=0).
- ADDR_W, 18, word address width of `de_addr`.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- de_req  in  1  access request, held by initiator until acknowledged.
- de_ack  out  1  one-cycle completion pulse.
- de_addr  in  ADDR_W  word address.
- de_nbyte  in  4  active-low byte enables; bit i enables bits [8i+7:8i].
- de_rnw  in  1  1 = read, 0 = write.
- de_w_data  in  32  write data.
- de_r_data  out  32  read data, valid while de_ack is high.
- sram_addr  out  ADDR_W+1  halfword address.
- sram_wdata  out  16  halfword write data.
- sram_rdata  in  16  halfword read data.
- sram_data_oe  out  1  1 = drive sram_wdata onto the bus.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_lb_n  out  1  SRAM lower byte enable, active low.
- sram_ub_n  out  1  SRAM upper byte enable, active low.

Behaviour:
- Reset (async) values:
  - State IDLE.
  - de_ack=0, de_r_data=0.
  - sram_we_n=1, sram_oe_n=1, sram_lb_n=1, sram_ub_n=1.
  - sram_data_oe=0, sram_addr=0, sram_wdata=0.
- Reset during an access aborts it immediately. No ack is issued; a partial write is permitted.
- All outputs are registered.
- States: IDLE, LO_BEAT, HI_BEAT, ACK.
- IDLE:
  - When de_req=1 at an edge, latch addr, nbyte, rnw and w_data.
  - Read -> LO_BEAT.
  - Write with nbyte[1:0]!=2'b11 -> LO_BEAT.
  - Else write with nbyte[3:2]!=2'b11 -> HI_BEAT.
  - Else (nbyte=4'b1111) -> ACK with no SRAM activity.
- Beat length is B = WAIT_CYCLES+2 cycles: 1 setup cycle, then WAIT_CYCLES+1 strobe cycles.
  - Setup cycle: sram_addr valid, byte enables valid, we_n=1. For reads, oe_n=0.
  - Strobe cycles: we_n=0 for writes; oe_n=0 held for reads.
  - Read data is captured from sram_rdata at the edge ending the last strobe cycle.
  - At beat end we_n and oe_n return to 1 in the same edge as the next transition.
- LO_BEAT:
  - sram_addr = {addr,1'b0}.
  - Write: sram_wdata = w_data[15:0], lb_n = nbyte[0], ub_n = nbyte[1].
  - Read: both byte enables low; captures de_r_data[15:0].
  - Next: HI_BEAT if read or nbyte[3:2]!=2'b11, else ACK.
- HI_BEAT:
  - sram_addr = {addr,1'b1}.
  - Write: sram_wdata = w_data[31:16], lb_n = nbyte[2], ub_n = nbyte[3].
  - Read: captures de_r_data[31:16].
  - Next: ACK.
- sram_data_oe=1 for the whole of a write beat, 0 otherwise.
- ACK:
  - de_ack=1 for exactly one cycle, then IDLE.
  - The request is not re-sampled in the ACK cycle. Minimum one IDLE cycle between accesses.
- de_r_data changes only on reads and holds between accesses.
- de_ack rises 2B, B, or 0 cycles after the request-sampling edge, for two beats, one beat, or no beats respectively.
- de_req dropping mid-access does not cancel the access; the ack is still pulsed.
- The top address (all ones) maps to halfwords 2^(ADDR_W+1)-2 and -1. There is no wrap logic.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE/LO_BEAT/HI_BEAT/ACK).
  - Beat-counter width, clog2(WAIT_CYCLES+2).
  - Byte-enable inactive constant 4'b1111.
- One natural sub-module: `sram_hword_beat`. It is a setup/strobe timer producing we_n/oe_n/capture/done for one halfword given start, rnw and WAIT_CYCLES.

Test Plan:
1. Assert reset mid-idle and mid-write beat -> we_n/oe_n/lb_n/ub_n=1, data_oe=0, de_ack=0 immediately (no clock edge needed); no ack after release.
2. Write addr 0x00010, nbyte 4'b1110, wdata 0x00000005, WAIT_CYCLES=1 -> only LO beat: sram_addr 0x00020, lb_n=0, ub_n=1, sram_wdata 0x0005, we_n low 2 cycles; de_ack pulse 3 cycles after sampling.
3. Write nbyte 4'b0111, wdata 0x07000000 -> HI beat only: sram_addr odd, sram_wdata 0x0700, ub_n=0, lb_n=1; no LO-beat activity.
4. Read addr 0x3FFFF, model returns 0x1234 (LO) and 0xABCD (HI) -> sram_addr 0x7FFFE then 0x7FFFF, de_r_data 0xABCD1234 with de_ack 6 cycles after sampling; we_n stays 1.
5. Write nbyte 4'b1111 -> de_ack the cycle after sampling; no we_n/oe_n activity.
6. de_req held high, addr/nbyte advanced on each ack through byte lanes 1110, 1101, 1011, 0111 -> four single-cycle acks, each separated by ≥1 IDLE cycle; SRAM receives exactly four beats with the correct lane.
